// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults for the register-file FIFO pointer controller
//   FIFO_ADDR_W    default address width
//   FIFO_DEPTH     default number of entries (2**FIFO_ADDR_W)
//   FIFO_AFULL_LVL default almost-full threshold
package fifo_pkg;
    localparam int FIFO_ADDR_W    = 6;
    localparam int FIFO_DEPTH     = 2 ** FIFO_ADDR_W;
    localparam int FIFO_AFULL_LVL = 60;
endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// fifo_ptr_ctrl_if: request/address/status bundle between FIFO users and the pointer controller
//   master: drives wr_req/rd_req, observes addresses, enables and status
//   slave : the controller, driving addresses, enables, flags, count and error pulses
interface fifo_ptr_ctrl_if import fifo_pkg::*; #(
    parameter int ADDR_W = FIFO_ADDR_W
);
    logic              wr_req;
    logic              rd_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              wr_err;
    logic              rd_err;
    modport master (
        output wr_req, rd_req,
        input  wr_addr, wr_en, rd_addr, rd_en, full, empty, almost_full, count, wr_err, rd_err
    );
    modport slave (
        input  wr_req, rd_req,
        output wr_addr, wr_en, rd_addr, rd_en, full, empty, almost_full, count, wr_err, rd_err
    );
endinterface

// File: rtl/fifo_ptr.sv
// fifo_ptr: W-bit incrementing pointer, MSB acts as the wrap bit
//   clk, rst : clock, asynchronous active-high reset
//   i_inc    : advance pointer by one on the next rising edge
//   o_ptr    : registered pointer value
module fifo_ptr #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);
    logic [W-1:0] r_ptr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ptr <= '0;
        else if (i_inc) r_ptr <= r_ptr + W'(1);
    end
    assign o_ptr = r_ptr;
endmodule

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: write/read pointer and flag controller for the register-file FIFO
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of fifo_ptr_ctrl_if
//              wr_req/rd_req in; wr_addr/rd_addr, wr_en/rd_en (combinational from
//              registered flags), full/empty/almost_full/count, wr_err/rd_err pulses out
module fifo_ptr_ctrl import fifo_pkg::*; #(
    parameter int ADDR_W    = FIFO_ADDR_W,
    parameter int AFULL_LVL = FIFO_AFULL_LVL
) (
    input  logic           clk,
    input  logic           rst,
    fifo_ptr_ctrl_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [ADDR_W:0] w_wptr;
    logic [ADDR_W:0] w_rptr;
    logic [ADDR_W:0] w_count_nxt;
    logic [ADDR_W:0] r_count;
    logic            w_wr_en;
    logic            w_rd_en;
    logic            r_full;
    logic            r_empty;
    logic            r_afull;
    logic            r_wr_err;
    logic            r_rd_err;
    assign w_wr_en     = bus.wr_req & ~r_full;
    assign w_rd_en     = bus.rd_req & ~r_empty;
    assign w_count_nxt = r_count + (ADDR_W+1)'(w_wr_en) - (ADDR_W+1)'(w_rd_en);
    fifo_ptr #(.W(ADDR_W + 1)) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_wr_en),
        .o_ptr (w_wptr)
    );
    fifo_ptr #(.W(ADDR_W + 1)) u_rptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_rd_en),
        .o_ptr (w_rptr)
    );
    // Flags are derived from the next count so they are valid right after the causing edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_full   <= w_count_nxt == (ADDR_W+1)'(DEPTH);
            r_empty  <= w_count_nxt == '0;
            r_afull  <= w_count_nxt >= (ADDR_W+1)'(AFULL_LVL);
            r_wr_err <= bus.wr_req & r_full;
            r_rd_err <= bus.rd_req & r_empty;
        end
    end
    assign bus.wr_addr     = w_wptr[ADDR_W-1:0];
    assign bus.rd_addr     = w_rptr[ADDR_W-1:0];
    assign bus.wr_en       = w_wr_en;
    assign bus.rd_en       = w_rd_en;
    assign bus.count       = r_count;
    assign bus.full        = r_full;
    assign bus.empty       = r_empty;
    assign bus.almost_full = r_afull;
    assign bus.wr_err      = r_wr_err;
    assign bus.rd_err      = r_rd_err;
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb_fifo_ptr_ctrl: directed and random checks of fifo_ptr_ctrl against a reference model
module tb_fifo_ptr_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [6:0] m_wp = '0;
    logic [6:0] m_rp = '0;
    int   m_cnt = 0;
    logic m_werr = 1'b0;
    logic m_rerr = 1'b0;
    fifo_ptr_ctrl_if bus ();
    fifo_ptr_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_wp = '0;
        m_rp = '0;
        m_cnt = 0;
        m_werr = 1'b0;
        m_rerr = 1'b0;
    endtask
    task automatic state_chk();
        chk("count", 32'(bus.count), m_cnt);
        chk("empty", 32'(bus.empty), 32'(m_cnt == 0));
        chk("full", 32'(bus.full), 32'(m_cnt == 64));
        chk("afull", 32'(bus.almost_full), 32'(m_cnt >= 60));
        chk("wr_addr", 32'(bus.wr_addr), 32'(m_wp[5:0]));
        chk("rd_addr", 32'(bus.rd_addr), 32'(m_rp[5:0]));
        chk("wrap_w", 32'(dut.w_wptr[6]), 32'(m_wp[6]));
        chk("wrap_r", 32'(dut.w_rptr[6]), 32'(m_rp[6]));
        chk("wr_err", 32'(bus.wr_err), 32'(m_werr));
        chk("rd_err", 32'(bus.rd_err), 32'(m_rerr));
    endtask
    // One clock of stimulus: check combinational enables and state before the edge, then step the model
    task automatic cyc(input logic w, input logic r);
        logic we;
        logic re;
        bus.wr_req = w;
        bus.rd_req = r;
        #1;
        we = w && (m_cnt != 64);
        re = r && (m_cnt != 0);
        state_chk();
        chk("wr_en", 32'(bus.wr_en), 32'(we));
        chk("rd_en", 32'(bus.rd_en), 32'(re));
        @(posedge clk);
        m_werr = w && (m_cnt == 64);
        m_rerr = r && (m_cnt == 0);
        m_wp = m_wp + 7'(we);
        m_rp = m_rp + 7'(re);
        m_cnt = m_cnt + int'(we) - int'(re);
        #1;
    endtask
    task automatic mid_reset();
        bus.wr_req = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_afull", 32'(bus.almost_full), 0);
        chk("rst_waddr", 32'(bus.wr_addr), 0);
        chk("rst_raddr", 32'(bus.rd_addr), 0);
        chk("rst_werr", 32'(bus.wr_err), 0);
        chk("rst_rerr", 32'(bus.rd_err), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.wr_req = 1'b0;
        model_reset();
    endtask
    initial begin
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        #12;
        chk("init_count", 32'(bus.count), 0);
        chk("init_empty", 32'(bus.empty), 1);
        chk("init_full", 32'(bus.full), 0);
        chk("init_rd_en", 32'(bus.rd_en), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) cyc(1'b1, 1'b0);
        chk("pre_rst_count", 32'(bus.count), 10);
        chk("pre_rst_waddr", 32'(bus.wr_addr), 10);
        mid_reset();
        for (int i = 0; i < 64; i++) begin
            chk("fill_waddr", 32'(bus.wr_addr), i);
            cyc(1'b1, 1'b0);
            chk("fill_afull", 32'(bus.almost_full), 32'(i >= 59));
        end
        chk("fill_count", 32'(bus.count), 64);
        chk("fill_full", 32'(bus.full), 1);
        cyc(1'b1, 1'b0);
        chk("ovf_werr", 32'(bus.wr_err), 1);
        chk("ovf_count", 32'(bus.count), 64);
        cyc(1'b0, 1'b0);
        chk("ovf_werr_clr", 32'(bus.wr_err), 0);
        for (int i = 0; i < 64; i++) begin
            chk("drain_raddr", 32'(bus.rd_addr), i);
            cyc(1'b0, 1'b1);
        end
        chk("drain_empty", 32'(bus.empty), 1);
        chk("drain_count", 32'(bus.count), 0);
        cyc(1'b0, 1'b1);
        chk("udf_rerr", 32'(bus.rd_err), 1);
        cyc(1'b0, 1'b0);
        chk("udf_rerr_clr", 32'(bus.rd_err), 0);
        cyc(1'b1, 1'b1);
        chk("both_empty_count", 32'(bus.count), 1);
        chk("both_empty_rerr", 32'(bus.rd_err), 1);
        chk("both_empty_werr", 32'(bus.wr_err), 0);
        repeat (63) cyc(1'b1, 1'b0);
        chk("refill_full", 32'(bus.full), 1);
        cyc(1'b1, 1'b1);
        chk("both_full_count", 32'(bus.count), 63);
        chk("both_full_werr", 32'(bus.wr_err), 1);
        chk("both_full_rerr", 32'(bus.rd_err), 0);
        mid_reset();
        repeat (10) cyc(1'b1, 1'b0);
        for (int i = 0; i < 200; i++) begin
            cyc(1'b1, 1'b1);
            chk("stream_count", 32'(bus.count), 10);
            chk("stream_full", 32'(bus.full), 0);
            chk("stream_empty", 32'(bus.empty), 0);
        end
        chk("stream_waddr", 32'(bus.wr_addr), 18);
        chk("stream_raddr", 32'(bus.rd_addr), 8);
        chk("stream_wbit", 32'(dut.w_wptr[6]), 1);
        chk("stream_rbit", 32'(dut.w_rptr[6]), 1);
        for (int i = 0; i < 5000; i++) begin
            if ((i / 500) % 2 == 0) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
            else cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
